// File: rtl/sa_feeder.sv
// Systolic-array feeder: loads one weight word, then streams skewed activations into 4 PE rows.
// Latency: lane k of an accepted activation word reaches the PEs after 1+k cycles (1 cycle with SA_FEEDER_SKEW_EN undefined).
// Backpressure: w_ready only in LOAD, a_ready only in STREAM; missing a_valid in STREAM injects an inactive bubble slot.
module sa_feeder #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           vec_len,
    input  logic                 w_valid,
    input  logic [8*LANES-1:0]   w_data,
    output logic                 w_ready,
    input  logic                 a_valid,
    input  logic [8*LANES-1:0]   a_data,
    output logic                 a_ready,
    output logic [1:0]           mode_o,
    output logic [8*LANES-1:0]   pe_in_o,
    output logic [8*LANES-1:0]   pe_filter_o,
    output logic [LANES-1:0]     activate_o,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WSET   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

`ifdef SA_FEEDER_SKEW_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif

    // DRAIN must cover the deepest lane so the last word fully leaves the pipeline.
    localparam logic [1:0] DRAIN_LAST = (SKEW != 0) ? 2'(LANES - 1) : 2'd0;

    logic [2:0]           state;
    logic [7:0]           vec_len_q;
    logic [7:0]           cnt;
    logic [1:0]           drain_cnt;
    logic [8*LANES-1:0]   w_q;
    logic                 done_q;
    logic                 a_hs;
    logic [8*LANES-1:0]   slot_dat;

    assign a_hs     = (state == S_STREAM) && a_valid;
    assign slot_dat = a_hs ? a_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            vec_len_q <= '0;
            cnt       <= '0;
            drain_cnt <= '0;
            w_q       <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        vec_len_q <= vec_len;
                        if (vec_len != 8'd0) begin
                            state <= S_LOAD;
                            cnt   <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_valid) begin
                        w_q   <= w_data;
                        state <= S_WSET;
                    end
                end
                S_WSET: begin
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (a_valid) begin
                        cnt <= cnt + 8'd1;
                        if ((cnt + 8'd1) == vec_len_q) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-lane delay line: {activate, byte}, depth k+1 with skew, depth 1 without.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int DEPTH = (SKEW != 0) ? k + 1 : 1;
        logic [8:0] sr [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j < DEPTH; j++) sr[j] <= '0;
            end else begin
                sr[0] <= {a_hs, slot_dat[8*k +: 8]};
                for (int j = 1; j < DEPTH; j++) sr[j] <= sr[j-1];
            end
        end

        assign pe_in_o[8*k +: 8] = sr[DEPTH-1][7:0];
        assign activate_o[k]     = sr[DEPTH-1][8];
    end

    always_comb begin
        mode_o = 2'd3;
        case (state)
            S_WSET:            mode_o = 2'd2;
            S_STREAM, S_DRAIN: mode_o = 2'd1;
            default:           mode_o = 2'd3;
        endcase
    end

    assign pe_filter_o = (state == S_WSET) ? w_q : '0;
    assign w_ready     = (state == S_LOAD);
    assign a_ready     = (state == S_STREAM);
    assign busy        = (state != S_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder; expectations follow the skew setting selected by SA_FEEDER_SKEW_EN.
module tb_sa_feeder;

`ifdef SA_FEEDER_SKEW_EN
    localparam int SK = 1;
`else
    localparam int SK = 0;
`endif
    localparam int ND = (SK != 0) ? 4 : 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  vec_len = '0;
    logic        w_valid = 1'b0;
    logic [31:0] w_data = '0;
    logic        w_ready;
    logic        a_valid = 1'b0;
    logic [31:0] a_data = '0;
    logic        a_ready;
    logic [1:0]  mode_o;
    logic [31:0] pe_in_o;
    logic [31:0] pe_filter_o;
    logic [3:0]  activate_o;
    logic        busy;
    logic        done;

    sa_feeder #(.LANES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .mode_o(mode_o), .pe_in_o(pe_in_o), .pe_filter_o(pe_filter_o),
        .activate_o(activate_o), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int hist_base = 0;
    logic in_stream = 1'b0;
    logic [31:0] hd [0:4095];
    logic [3:0]  ha [0:4095];
    int act_cnt [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Lane k now shows the slot that entered 1+k*SK cycles ago.
    task automatic check_lanes();
        logic [31:0] ep;
        logic [3:0]  ea;
        int idx;
        ep = '0;
        ea = '0;
        for (int k = 0; k < 4; k++) begin
            idx = cyc - 1 - k * SK;
            if (idx >= hist_base) begin
                ep[8*k +: 8] = hd[idx][8*k +: 8];
                ea[k]        = ha[idx][k];
            end
        end
        chk("pe_in_o", pe_in_o, ep);
        chk("activate_o", {28'd0, activate_o}, {28'd0, ea});
        if (ea != 4'd0) chk("mode_when_active", {30'd0, mode_o}, 32'd1);
        for (int k = 0; k < 4; k++) act_cnt[k] += int'(activate_o[k]);
    endtask

    task automatic cycle();
        hd[cyc] = (in_stream && a_valid) ? a_data : 32'd0;
        ha[cyc] = (in_stream && a_valid) ? 4'hF : 4'h0;
        @(posedge clk);
        #1;
        cyc++;
        check_lanes();
    endtask

    task automatic do_job(input logic [7:0] len, input logic [31:0] w, input logic [31:0] base,
                          input int bubble_at, input logic start_mid);
        for (int k = 0; k < 4; k++) act_cnt[k] = 0;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        vec_len = len;
        cycle();
        start = 1'b0;
        vec_len = 8'd0;
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_w_ready", {31'd0, w_ready}, 32'd1);
        chk("load_mode", {30'd0, mode_o}, 32'd3);
        chk("load_a_ready", {31'd0, a_ready}, 32'd0);
        cycle();
        chk("load_hold", {31'd0, w_ready}, 32'd1);
        w_valid = 1'b1;
        w_data = w;
        cycle();
        w_valid = 1'b0;
        w_data = 32'hDEAD_BEEF;
        chk("wset_mode", {30'd0, mode_o}, 32'd2);
        chk("wset_filter", pe_filter_o, w);
        chk("wset_w_ready", {31'd0, w_ready}, 32'd0);
        chk("wset_a_ready", {31'd0, a_ready}, 32'd0);
        cycle();
        in_stream = 1'b1;
        for (int i = 0; i < int'(len); i++) begin
            if (i == bubble_at) begin
                a_valid = 1'b0;
                chk("bubble_a_ready", {31'd0, a_ready}, 32'd1);
                cycle();
            end
            a_valid = 1'b1;
            a_data = base + 32'(i) * 32'h0101_0101;
            chk("stream_a_ready", {31'd0, a_ready}, 32'd1);
            chk("stream_mode", {30'd0, mode_o}, 32'd1);
            chk("stream_filter", pe_filter_o, 32'd0);
            if (start_mid && i == 1) begin
                start = 1'b1;
                vec_len = 8'd5;
            end
            cycle();
            start = 1'b0;
        end
        in_stream = 1'b0;
        a_valid = 1'b0;
        for (int d = 0; d < ND; d++) begin
            chk("drain_a_ready", {31'd0, a_ready}, 32'd0);
            chk("drain_busy", {31'd0, busy}, 32'd1);
            chk("drain_mode", {30'd0, mode_o}, 32'd1);
            chk("drain_done", {31'd0, done}, 32'd0);
            cycle();
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_mode", {30'd0, mode_o}, 32'd3);
        for (int k = 0; k < 4; k++) chk("active_slots", act_cnt[k], 32'(len));
        cycle();
        chk("done_once", {31'd0, done}, 32'd0);
        chk("stay_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mode"}, {30'd0, mode_o}, 32'd3);
        chk({tag, "_pe_in"}, pe_in_o, 32'd0);
        chk({tag, "_filter"}, pe_filter_o, 32'd0);
        chk({tag, "_act"}, {28'd0, activate_o}, 32'd0);
        chk({tag, "_w_ready"}, {31'd0, w_ready}, 32'd0);
        chk({tag, "_a_ready"}, {31'd0, a_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        rst = 1'b0;
        hist_base = cyc;
        cycle();
        chk_reset_outputs("post_rst");

        // Single vector, reference data
        do_job(8'd1, 32'h0403_0201, 32'h0D0C_0B0A, -1, 1'b0);

        // Three vectors with one bubble between words 1 and 2
        do_job(8'd3, 32'h1122_3344, 32'hA0B0_C0D0, 1, 1'b0);

        // Zero-length job
        start = 1'b1;
        vec_len = 8'd0;
        cycle();
        start = 1'b0;
        chk("zlen_busy", {31'd0, busy}, 32'd0);
        chk("zlen_w_ready", {31'd0, w_ready}, 32'd0);
        chk("zlen_done", {31'd0, done}, 32'd1);
        cycle();
        chk("zlen_done_once", {31'd0, done}, 32'd0);
        chk("zlen_idle", {31'd0, busy}, 32'd0);

        // Reset mid-stream after 2 of 5 words
        start = 1'b1;
        vec_len = 8'd5;
        cycle();
        start = 1'b0;
        w_valid = 1'b1;
        w_data = 32'h5555_AAAA;
        cycle();
        w_valid = 1'b0;
        cycle();
        in_stream = 1'b1;
        a_valid = 1'b1;
        a_data = 32'h1111_1111;
        cycle();
        a_data = 32'h2222_2222;
        cycle();
        in_stream = 1'b0;
        a_valid = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        cyc++;
        chk_reset_outputs("mid_rst_edge");
        rst = 1'b0;
        hist_base = cyc;
        cycle();
        do_job(8'd2, 32'h0908_0706, 32'h4030_2010, -1, 1'b0);

        // Start pulsed during STREAM is ignored
        do_job(8'd4, 32'hCAFE_F00D, 32'h0102_0304, -1, 1'b1);

        // Longest job: counter must not wrap
        do_job(8'd255, 32'h7F7F_7F7F, 32'h0000_0001, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_feeder.md
SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 SHALL have parameter: LANES, 4, number of PE rows fed (fixed at 4 for this revision).
REQ-002 SHALL have ports:
  clk  in  1  clock, rising edge
  rst  in  1  reset, asynchronous, active-high
  start  in  1  begin job (sampled in IDLE only)
  vec_len  in  8  activation vectors per job
  w_valid  in  1  weight word valid
  w_data  in  32  four packed weights, lane k = bits [8k+7:8k]
  w_ready  out  1  weight word accepted when w_valid high
  a_valid  in  1  activation word valid
  a_data  in  32  four packed activations, lane k = bits [8k+7:8k]
  a_ready  out  1  activation word accepted when a_valid high
  mode_o  out  2  PE mode: 0 single, 1 systolic, 2 save, 3 initial
  pe_in_o  out  32  per-lane PE data input
  pe_filter_o  out  32  per-lane PE filter/partial-sum input
  activate_o  out  4  per-lane PE activate
  busy  out  1  job in progress
  done  out  1  one-cycle job-complete pulse

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, WSET, STREAM, DRAIN.
REQ-004 IDLE: start=1 and vec_len!=0 -> LOAD; start=1 and vec_len=0 -> stay IDLE, done=1 next cycle; vec_len SHALL be latched on start.
REQ-005 LOAD: w_ready=1; w_valid handshake latches w_data -> WSET; without handshake, stay in LOAD indefinitely.
REQ-006 WSET: exactly one cycle; mode_o=2; pe_filter_o=latched weights; then -> STREAM.
REQ-007 STREAM: a_ready=1; each handshake increments a vector counter; the handshake that makes count equal vec_len -> DRAIN.
REQ-008 Skew: activation byte k of the word accepted in cycle t SHALL appear on pe_in_o lane k with activate_o[k]=1 in cycle t+1+k.
REQ-009 Bubble: a STREAM cycle without handshake SHALL produce lane slots with pe_in_o byte 0 and activate_o bit 0, skewed identically.
REQ-010 DRAIN: a_ready=0; lasts 1+(LANES-1) cycles with skew, 1 cycle without; then -> IDLE with done=1 for exactly the first IDLE cycle.
REQ-011 mode_o SHALL be combinational from state: IDLE/LOAD=3, WSET=2, STREAM/DRAIN=1; mode_o SHALL be 1 in every cycle any activate_o bit is high.
REQ-012 pe_filter_o SHALL be 0 in every state except WSET (zero partial-sum injection in systolic mode).
REQ-013 busy SHALL be 1 in LOAD, WSET, STREAM, DRAIN; start while busy SHALL be ignored.
REQ-014 w_ready SHALL be 0 outside LOAD; a_ready SHALL be 0 outside STREAM.
REQ-015 Counter SHALL be 8 bits and cleared on entry to LOAD; vec_len=255 SHALL complete without wrap.

Reset
REQ-016 rst SHALL force IDLE, clear counter, weight register and skew pipeline, at any time including mid-job.
REQ-017 While rst asserted and after release: mode_o=3, pe_in_o=0, pe_filter_o=0, activate_o=0, w_ready=0, a_ready=0, busy=0, done=0.

Configuration
REQ-018 Macro SA_FEEDER_SKEW_EN: defined -> diagonal skew per REQ-008, DRAIN length LANES cycles.
REQ-019 Without SA_FEEDER_SKEW_EN: all lanes SHALL have latency 1 (lane k at t+1), DRAIN length 1 cycle; all other behaviour unchanged.

Verification
REQ-020 start, vec_len=1, w_data=0x04030201, a_data=0x0D0C0B0A (skew on) -> WSET mode_o=2, pe_filter_o=0x04030201; lane0=0x0A at t+1 ... lane3=0x0D at t+4; done one cycle after last DRAIN cycle.
REQ-021 vec_len=3, a_valid low for one cycle between words 1 and 2 -> one all-zero activate slot per lane, 3 active slots per lane, done after 3 handshakes plus DRAIN.
REQ-022 start with vec_len=0 -> no LOAD, busy stays 0, done=1 in the next cycle.
REQ-023 rst asserted during STREAM after 2 of 5 words -> all outputs to reset values immediately; new start with vec_len=2 completes normally.
REQ-024 start pulsed during STREAM -> ignored; exactly one done per job.
REQ-025 Skew off, vec_len=2 -> all four lanes valid in the same cycle t+1, DRAIN one cycle, done at T+2.
